// File: rtl/mem_burst_reader.sv
// Burst read sequencer: register-file read port to a registered valid/ready word stream.
// Optional MEM_BURST_READER_WRAP_EN: address wraps at Depth instead of truncating the burst.
module mem_burst_reader #(
    parameter int BitWidth = 8,
    parameter int Depth    = 16,
    parameter int MaxLen   = 16,
    localparam int AddrW   = $clog2(Depth),
    localparam int LenW    = $clog2(MaxLen + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AddrW-1:0]    req_addr,
    input  logic [LenW-1:0]     req_len,
    output logic                mem_rEn,
    output logic [AddrW-1:0]    mem_rAddr,
    input  logic [BitWidth-1:0] mem_dOUT,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BitWidth-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                err
);

    localparam int CW = ((LenW > AddrW) ? LenW : AddrW) + 2;

    typedef enum logic {IDLE, READ} state_t;

    state_t              state_q, state_d;
    logic [AddrW-1:0]    cur_addr_q, cur_addr_d;
    logic [LenW-1:0]     rem_q, rem_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [BitWidth-1:0] out_data_q, out_data_d;
    logic                err_q, err_d;

    logic             accept, load, over_len, bad_req;
    logic [LenW-1:0]  len_clamp, eff_len;
    logic [AddrW-1:0] next_addr;
`ifndef MEM_BURST_READER_WRAP_EN
    logic [CW-1:0]    avail;
`endif

    always_comb begin
        over_len  = req_len > LenW'(MaxLen);
        len_clamp = over_len ? LenW'(MaxLen) : req_len;
        eff_len   = len_clamp;
        bad_req   = over_len;
`ifdef MEM_BURST_READER_WRAP_EN
        next_addr = (cur_addr_q == AddrW'(Depth - 1)) ? '0 : cur_addr_q + 1'b1;
`else
        next_addr = cur_addr_q + 1'b1;
        avail     = CW'(Depth) - CW'(req_addr);
        // Start beyond the array yields an empty burst; otherwise cut at the top word.
        if (CW'(req_addr) >= CW'(Depth)) begin
            eff_len = '0;
            bad_req = 1'b1;
        end else if (CW'(len_clamp) > avail) begin
            eff_len = LenW'(avail);
            bad_req = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        err_d       = err_q;

        accept = clk_en & req_valid & (state_q == IDLE);
        load   = clk_en & (state_q == READ) & (~out_valid_q | out_ready);

        if (clk_en) err_d = 1'b0;

        if (accept) begin
            cur_addr_d = req_addr;
            rem_d      = eff_len;
            err_d      = bad_req;
            state_d    = (eff_len != '0) ? READ : IDLE;
        end

        if (load) begin
            out_data_d  = mem_dOUT;
            out_valid_d = 1'b1;
            out_last_d  = (rem_q == LenW'(1));
            cur_addr_d  = next_addr;
            rem_d       = rem_q - 1'b1;
            if (rem_q == LenW'(1)) state_d = IDLE;
        end else if (clk_en & out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_rEn   = (state_q == READ);
    assign mem_rAddr = cur_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE) | out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader against a memory holding 8'hA0+i at word i.
module tb_mem_burst_reader;

    localparam int BitWidth = 8;
    localparam int Depth    = 16;
    localparam int MaxLen   = 16;
    localparam int AddrW    = 4;
    localparam int LenW     = 5;

    logic                clk = 1'b0;
    logic                rst, clk_en, req_valid, req_ready;
    logic [AddrW-1:0]    req_addr;
    logic [LenW-1:0]     req_len;
    logic                mem_rEn;
    logic [AddrW-1:0]    mem_rAddr;
    logic [BitWidth-1:0] mem_dOUT;
    logic                out_valid, out_ready, out_last, busy, err;
    logic [BitWidth-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    logic [8:0] got_q[$];

    always #5 clk = ~clk;

    assign mem_dOUT = 8'hA0 + {4'h0, mem_rAddr};

    mem_burst_reader #(.BitWidth(BitWidth), .Depth(Depth), .MaxLen(MaxLen)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .mem_rEn(mem_rEn), .mem_rAddr(mem_rAddr), .mem_dOUT(mem_dOUT),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    // Record every completed output handshake and every err pulse.
    always @(posedge clk) begin
        if (!rst && clk_en) begin
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        err_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            step();
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic run_burst(input string tag, input int addr, input int len);
        req_valid = 1'b1;
        req_addr  = AddrW'(addr);
        req_len   = LenW'(len);
        step();
        req_valid = 1'b0;
        wait_idle(tag);
    endtask

    task automatic expect_words(input string tag, input int base, input int n);
        logic [7:0] d;
        logic [8:0] e;
        check({tag, "_cnt"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            d = 8'hA0 + 8'((base + i) % Depth);
            e = {(i == n - 1), d};
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(e));
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_ren",   32'(mem_rEn),   32'd0);
        check("rst_raddr", 32'(mem_rAddr), 32'd0);
        rst = 1'b0;
        step();

        // Basic burst, cycle by cycle.
        clear_log();
        req_valid = 1'b1; req_addr = 4'd3; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        check("b1_acc_ready", 32'(req_ready), 32'd0);
        check("b1_acc_ren",   32'(mem_rEn),   32'd1);
        check("b1_acc_raddr", 32'(mem_rAddr), 32'd3);
        check("b1_acc_valid", 32'(out_valid), 32'd0);
        check("b1_acc_busy",  32'(busy),      32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b1_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("b1_data%0d", i),  32'(out_data),  32'(8'hA3 + i));
            check($sformatf("b1_last%0d", i),  32'(out_last),  32'(i == 3));
        end
        check("b1_end_ready", 32'(req_ready), 32'd1);
        check("b1_end_busy",  32'(busy),      32'd1);
        step();
        check("b1_drain_valid", 32'(out_valid), 32'd0);
        check("b1_drain_busy",  32'(busy),      32'd0);
        check("b1_err", 32'(err_cnt), 32'd0);
        expect_words("b1", 3, 4);

        // Backpressure on the second word.
        clear_log();
        req_valid = 1'b1; req_addr = 4'd3; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        step(); step();
        check("st_first", 32'(out_data), 32'hA4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("st_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("st_data%0d", i),  32'(out_data),  32'hA4);
            check($sformatf("st_last%0d", i),  32'(out_last),  32'd0);
        end
        out_ready = 1'b1;
        wait_idle("st");
        expect_words("st", 3, 4);

        // Clock enable low mid-burst.
        clear_log();
        req_valid = 1'b1; req_addr = 4'd3; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        step(); step();
        clk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("ce_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("ce_data%0d", i),  32'(out_data),  32'hA4);
            check($sformatf("ce_raddr%0d", i), 32'(mem_rAddr), 32'd5);
        end
        clk_en = 1'b1;
        wait_idle("ce");
        expect_words("ce", 3, 4);

        // Burst crossing the top of the array.
        clear_log();
        run_burst("top", 14, 4);
`ifdef MEM_BURST_READER_WRAP_EN
        expect_words("top", 14, 4);
        check("top_err", 32'(err_cnt), 32'd0);
`else
        expect_words("top", 14, 2);
        check("top_err", 32'(err_cnt), 32'd1);
`endif

        // Zero-length request.
        clear_log();
        req_valid = 1'b1; req_addr = 4'd5; req_len = 5'd0;
        step();
        req_valid = 1'b0;
        check("z_ready", 32'(req_ready), 32'd1);
        check("z_valid", 32'(out_valid), 32'd0);
        check("z_busy",  32'(busy),      32'd0);
        step();
        check("z_valid2", 32'(out_valid), 32'd0);
        check("z_cnt", 32'(got_q.size()), 32'd0);
        check("z_err", 32'(err_cnt), 32'd0);

        // Over-length request clamps to MaxLen.
        clear_log();
        run_burst("ol", 0, 20);
        expect_words("ol", 0, 16);
        check("ol_err", 32'(err_cnt), 32'd1);

        // Reset on the second word, then a clean burst.
        clear_log();
        req_valid = 1'b1; req_addr = 4'd3; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        step(); step();
        check("rs_pre", 32'(out_data), 32'hA4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_busy",  32'(busy),      32'd0);
        check("rs_ready", 32'(req_ready), 32'd1);
        check("rs_last",  32'(out_last),  32'd0);
        clear_log();
        run_burst("rs", 3, 4);
        expect_words("rs", 3, 4);
        check("rs_err", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
